// File: rtl/rob_commit_unit_if.sv
// rob_commit_unit_if: dispatch, pointer-block, writeback and commit signals of the ROB commit unit
interface rob_commit_if #(
  parameter int ROBsize      = 16,
  parameter int addrSize     = $clog2(ROBsize),
  parameter int dataWidth    = 32,
  parameter int regAddrWidth = 5
);
  logic                    alloc_i;
  logic [regAddrWidth-1:0] allocDest_i;
  logic                    allocRegWrite_i;
  logic [addrSize-1:0]     tail_i;
  logic                    tailReset_i;
  logic [addrSize-1:0]     head_i;
  logic                    stall_i;
  logic [addrSize-1:0]     allocTag_o;
  logic                    wbValid_i;
  logic [addrSize-1:0]     wbTag_i;
  logic [dataWidth-1:0]    wbData_i;
  logic                    wbMispredict_i;
  logic                    updateHead_o;
  logic                    commitValid_o;
  logic [regAddrWidth-1:0] commitDest_o;
  logic [dataWidth-1:0]    commitData_o;
  logic                    flush_o;
  modport master (
    output alloc_i, allocDest_i, allocRegWrite_i, tail_i, tailReset_i, head_i, stall_i,
    output wbValid_i, wbTag_i, wbData_i, wbMispredict_i,
    input  allocTag_o, updateHead_o, commitValid_o, commitDest_o, commitData_o, flush_o
  );
  modport slave (
    input  alloc_i, allocDest_i, allocRegWrite_i, tail_i, tailReset_i, head_i, stall_i,
    input  wbValid_i, wbTag_i, wbData_i, wbMispredict_i,
    output allocTag_o, updateHead_o, commitValid_o, commitDest_o, commitData_o, flush_o
  );
endinterface

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: ROB entry store with in-order retirement and one-cycle mispredict flush
module rob_commit_unit #(
  parameter int ROBsize      = 16,
  parameter int addrSize     = $clog2(ROBsize),
  parameter int dataWidth    = 32,
  parameter int regAddrWidth = 5
) (
  input logic clk_i,
  input logic reset_i,
  rob_commit_if.slave rob
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ROBsize-1:0] valid_q, valid_d, done_q, done_d, misp_q, misp_d, regw_q, regw_d;
  logic [regAddrWidth-1:0] dest_q [ROBsize];
  logic [regAddrWidth-1:0] dest_d [ROBsize];
  logic [dataWidth-1:0] data_q [ROBsize];
  logic [dataWidth-1:0] data_d [ROBsize];
  logic commit_valid_q, commit_valid_d, flush_q, flush_d;
  logic [regAddrWidth-1:0] commit_dest_q, commit_dest_d;
  logic [dataWidth-1:0] commit_data_q, commit_data_d;
  logic [addrSize-1:0] alloc_tag;
  logic run, alloc_en, wb_en, update_head;
  assign run         = state_q == RUN;
  assign alloc_tag   = rob.tailReset_i ? rob.tail_i + addrSize'(1) : '0;
  assign alloc_en    = rob.alloc_i & ~rob.stall_i & run;
  assign wb_en       = rob.wbValid_i & run & valid_q[rob.wbTag_i];
  assign update_head = run & valid_q[rob.head_i] & done_q[rob.head_i];
  // later assignments win: alloc overrides a same-index retire or writeback
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    misp_d  = misp_q;
    regw_d  = regw_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (update_head) valid_d[rob.head_i] = 1'b0;
    if (wb_en) begin
      done_d[rob.wbTag_i] = 1'b1;
      misp_d[rob.wbTag_i] = rob.wbMispredict_i;
      data_d[rob.wbTag_i] = rob.wbData_i;
    end
    if (alloc_en) begin
      valid_d[alloc_tag] = 1'b1;
      done_d[alloc_tag]  = 1'b0;
      misp_d[alloc_tag]  = 1'b0;
      regw_d[alloc_tag]  = rob.allocRegWrite_i;
      dest_d[alloc_tag]  = rob.allocDest_i;
    end
    if (!run) begin
      valid_d = '0;
      done_d  = '0;
    end
    commit_valid_d = update_head & regw_q[rob.head_i];
    commit_dest_d  = update_head ? dest_q[rob.head_i] : commit_dest_q;
    commit_data_d  = update_head ? data_q[rob.head_i] : commit_data_q;
    flush_d        = update_head & misp_q[rob.head_i];
    state_d        = flush_d ? FLUSH : RUN;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= RUN;
      valid_q        <= '0;
      done_q         <= '0;
      misp_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      misp_q         <= misp_d;
      commit_valid_q <= commit_valid_d;
      commit_dest_q  <= commit_dest_d;
      commit_data_q  <= commit_data_d;
      flush_q        <= flush_d;
    end
  end
  // payload is only read behind valid/done, so it needs no reset
  always_ff @(posedge clk_i) begin
    regw_q <= regw_d;
    dest_q <= dest_d;
    data_q <= data_d;
  end
  assign rob.allocTag_o    = alloc_tag;
  assign rob.updateHead_o  = update_head;
  assign rob.commitValid_o = commit_valid_q;
  assign rob.commitDest_o  = commit_dest_q;
  assign rob.commitData_o  = commit_data_q;
  assign rob.flush_o       = flush_q;
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed and randomized checks of the ROB commit unit against an entry-level model
module tb_rob_commit_unit;
  localparam int RS = 16, AW = 4, DW = 32, RW = 5;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  rob_commit_if #(.ROBsize(RS), .addrSize(AW), .dataWidth(DW), .regAddrWidth(RW)) bus();
  rob_commit_unit #(.ROBsize(RS), .addrSize(AW), .dataWidth(DW), .regAddrWidth(RW)) dut (
    .clk_i(clk), .reset_i(rst), .rob(bus)
  );
  int vectors = 0, miscompares = 0;
  bit m_valid [RS], m_done [RS], m_regw [RS], m_misp [RS];
  logic [RW-1:0] m_dest [RS];
  logic [DW-1:0] m_data [RS];
  bit m_flushing, m_cv, m_flush;
  logic [RW-1:0] m_cd;
  logic [DW-1:0] m_cdata;
  bit last_acc, last_upd;
  logic [AW-1:0] last_tag, p_head, p_tail;
  bit p_tr;
  int p_cnt;
  function automatic logic [AW-1:0] exp_tag();
    return bus.tailReset_i ? AW'(bus.tail_i + 1) : '0;
  endfunction
  function automatic bit exp_upd();
    return !m_flushing && m_valid[bus.head_i] && m_done[bus.head_i];
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < RS; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_misp[i] = 0;
    end
    m_flushing = 0; m_flush = 0; m_cv = 0; m_cd = '0; m_cdata = '0;
  endtask
  task automatic model_step();
    bit upd, acc, wb;
    logic [AW-1:0] h, t, w;
    h = bus.head_i; t = exp_tag(); w = bus.wbTag_i;
    upd = exp_upd();
    acc = bus.alloc_i && !bus.stall_i && !m_flushing;
    wb  = bus.wbValid_i && !m_flushing && m_valid[w];
    last_acc = acc; last_upd = upd; last_tag = t;
    if (m_flushing) begin
      for (int i = 0; i < RS; i++) begin
        m_valid[i] = 0; m_done[i] = 0;
      end
      m_flushing = 0; m_flush = 0; m_cv = 0;
      return;
    end
    m_cv = upd && m_regw[h];
    if (upd) begin
      m_cd = m_dest[h]; m_cdata = m_data[h];
    end
    m_flush = upd && m_misp[h];
    m_flushing = m_flush;
    if (upd) m_valid[h] = 0;
    if (wb) begin
      m_done[w] = 1; m_data[w] = bus.wbData_i; m_misp[w] = bus.wbMispredict_i;
    end
    if (acc) begin
      m_valid[t] = 1; m_done[t] = 0; m_misp[t] = 0;
      m_dest[t] = bus.allocDest_i; m_regw[t] = bus.allocRegWrite_i;
    end
  endtask
  always @(negedge clk) begin
    check("allocTag", bus.allocTag_o, exp_tag());
    check("updateHead", bus.updateHead_o, exp_upd());
    check("commitValid", bus.commitValid_o, m_cv);
    check("commitDest", bus.commitDest_o, m_cd);
    check("commitData", bus.commitData_o, m_cdata);
    check("flush", bus.flush_o, m_flush);
  end
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    else begin
      last_acc = 0; last_upd = 0;
    end
    #1;
  endtask
  task automatic idle();
    bus.alloc_i = 0; bus.stall_i = 0; bus.wbValid_i = 0; bus.wbMispredict_i = 0;
  endtask
  task automatic do_reset();
    rst = 1; model_reset(); idle();
    bus.head_i = 0; bus.tail_i = 0; bus.tailReset_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic alloc(input bit tr, input logic [AW-1:0] tl, input logic [RW-1:0] d, input bit rw);
    bus.alloc_i = 1; bus.tailReset_i = tr; bus.tail_i = tl; bus.allocDest_i = d; bus.allocRegWrite_i = rw;
    cycle();
    bus.alloc_i = 0;
  endtask
  task automatic wb(input logic [AW-1:0] t, input logic [DW-1:0] d, input bit mp);
    bus.wbValid_i = 1; bus.wbTag_i = t; bus.wbData_i = d; bus.wbMispredict_i = mp;
    cycle();
    bus.wbValid_i = 0; bus.wbMispredict_i = 0;
  endtask
  initial begin
    int q [$];
    idle();
    bus.head_i = 0; bus.tail_i = 0; bus.tailReset_i = 0;
    bus.allocDest_i = 0; bus.allocRegWrite_i = 0; bus.wbTag_i = 0; bus.wbData_i = 0;
    model_reset();
    do_reset();
    #1;
    check("rst_commitValid", bus.commitValid_o, 0);
    check("rst_flush", bus.flush_o, 0);
    check("rst_commitDest", bus.commitDest_o, 0);
    check("rst_updateHead", bus.updateHead_o, 0);
    bus.alloc_i = 1; bus.allocDest_i = 3; bus.allocRegWrite_i = 1; #1;
    check("first_allocTag", bus.allocTag_o, 0);
    cycle(); bus.alloc_i = 0; #1;
    check("no_commit_before_wb", bus.updateHead_o, 0);
    wb(0, 32'hDEADBEEF, 0); #1;
    check("wb_then_updateHead", bus.updateHead_o, 1);
    cycle(); bus.head_i = 1; #1;
    check("commit_valid", bus.commitValid_o, 1);
    check("commit_dest", bus.commitDest_o, 3);
    check("commit_data", bus.commitData_o, 32'hDEADBEEF);
    bus.tailReset_i = 1; bus.tail_i = 15; bus.head_i = 0; #1;
    check("wrap_allocTag", bus.allocTag_o, 0);
    bus.alloc_i = 1; bus.stall_i = 1; cycle(); bus.alloc_i = 0; bus.stall_i = 0;
    wb(0, 32'h1, 0); #1;
    check("stall_blocks_alloc", bus.updateHead_o, 0);
    do_reset();
    alloc(0, 0, 1, 1); alloc(1, 0, 7, 1); alloc(1, 1, 9, 1);
    bus.tail_i = 2; bus.head_i = 1;
    wb(2, 32'h22, 0); #1;
    check("ooo_wait_for_head", bus.updateHead_o, 0);
    wb(1, 32'h11, 0); #1;
    check("ooo_head_ready", bus.updateHead_o, 1);
    cycle(); bus.head_i = 2; #1;
    check("ooo_first_dest", bus.commitDest_o, 7);
    check("ooo_first_data", bus.commitData_o, 32'h11);
    check("ooo_second_ready", bus.updateHead_o, 1);
    cycle(); bus.head_i = 3; #1;
    check("ooo_second_dest", bus.commitDest_o, 9);
    check("ooo_second_data", bus.commitData_o, 32'h22);
    do_reset();
    alloc(0, 0, 4, 0); alloc(1, 0, 5, 1); alloc(1, 1, 6, 1);
    bus.tail_i = 2; bus.head_i = 0;
    wb(1, 32'h1, 0); wb(2, 32'h2, 0); wb(0, 32'h3, 1); #1;
    check("misp_head_ready", bus.updateHead_o, 1);
    cycle(); bus.head_i = 0; bus.tail_i = 0; bus.tailReset_i = 0; #1;
    check("misp_flush", bus.flush_o, 1);
    check("misp_no_regwrite", bus.commitValid_o, 0);
    cycle(); #1;
    check("flush_one_cycle", bus.flush_o, 0);
    bus.head_i = 1; #1;
    check("flushed_entry1", bus.updateHead_o, 0);
    bus.head_i = 2; #1;
    check("flushed_entry2", bus.updateHead_o, 0);
    do_reset();
    alloc(0, 0, 8, 1);
    wb(0, 32'hAB, 1);
    cycle(); #1;
    check("pre_async_flush", bus.flush_o, 1);
    check("pre_async_commit", bus.commitValid_o, 1);
    rst = 1; model_reset(); #1;
    check("async_flush", bus.flush_o, 0);
    check("async_commit", bus.commitValid_o, 0);
    #2 rst = 0;
    wb(0, 32'h5, 0); #1;
    check("async_cleared", bus.updateHead_o, 0);
    do_reset();
    p_head = 0; p_tail = 0; p_tr = 0; p_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.head_i = p_head; bus.tail_i = p_tail; bus.tailReset_i = p_tr;
      bus.stall_i = (p_cnt == RS) || ($urandom % 8 == 0);
      bus.alloc_i = $urandom % 2;
      bus.allocDest_i = RW'($urandom); bus.allocRegWrite_i = $urandom % 2;
      q.delete();
      for (int i = 0; i < RS; i++) if (m_valid[i] && !m_done[i]) q.push_back(i);
      bus.wbValid_i = $urandom % 2;
      bus.wbTag_i = (q.size() > 0 && $urandom % 8 != 0) ? AW'(q[$urandom % q.size()]) : AW'($urandom);
      bus.wbData_i = $urandom;
      bus.wbMispredict_i = ($urandom % 12 == 0);
      cycle();
      if (m_flush) begin
        p_head = 0; p_tail = 0; p_tr = 0; p_cnt = 0;
      end else begin
        if (last_acc) begin
          p_tail = last_tag; p_tr = 1; p_cnt++;
        end
        if (last_upd) begin
          p_head++; p_cnt--;
        end
      end
      if ($urandom % 500 == 0) begin
        #2 rst = 1; model_reset();
        #1 rst = 0;
        p_head = 0; p_tail = 0; p_tr = 0; p_cnt = 0;
      end
    end
    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
